// File: rtl/mdu_issue_ctrl_if.sv
// Signal bundle between the dual-issue pipeline, the mul/div issue controller
// and the shared iterative multiply/divide unit.
interface mdu_issue_ctrl_if;
    logic        req0_valid;
    logic        req0_is_div;
    logic        req0_signed;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_is_div;
    logic        req1_signed;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        flush;
    logic [1:0]  mult_op;
    logic [1:0]  div_op;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        mult_done;
    logic        div_done;
    logic [63:0] mult_result;
    logic [63:0] div_result;
    logic        stall;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        busy;

    // Controller side
    modport slave (
        input  req0_valid, req0_is_div, req0_signed, req0_a, req0_b,
        input  req1_valid, req1_is_div, req1_signed, req1_a, req1_b,
        input  flush, mult_done, div_done, mult_result, div_result,
        output mult_op, div_op, opa, opb, stall, hilo_we, hilo_wdata, busy
    );

    // Pipeline / unit side
    modport master (
        output req0_valid, req0_is_div, req0_signed, req0_a, req0_b,
        output req1_valid, req1_is_div, req1_signed, req1_a, req1_b,
        output flush, mult_done, div_done, mult_result, div_result,
        input  mult_op, div_op, opa, opb, stall, hilo_we, hilo_wdata, busy
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Issue controller that serialises up to two mul/div requests onto one shared
// iterative unit and writes each result to HI/LO, with flush and drain support.
module mdu_issue_ctrl (
    input  logic             clk,
    input  logic             reset,
    mdu_issue_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ISSUE  = 3'd1,
        S_WAIT   = 3'd2,
        S_COMMIT = 3'd3,
        S_DRAIN  = 3'd4
    } state_t;

    typedef struct packed {
        logic        is_div;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
    } req_t;

    state_t      state_q, state_d;
    req_t        cur_q, cur_d;
    req_t        pend_q, pend_d;
    logic        pend_v_q, pend_v_d;
    logic        done_prev_q, done_prev_d;
    logic [63:0] res_q, res_d;
    logic [7:0]  wdog_q, wdog_d;

    req_t        slot0, slot1;
    logic        any_valid;
    logic        sel_done;
    logic        done_rise;
    logic [1:0]  start_code;

    assign slot0     = {bus.req0_is_div, bus.req0_signed, bus.req0_a, bus.req0_b};
    assign slot1     = {bus.req1_is_div, bus.req1_signed, bus.req1_a, bus.req1_b};
    assign any_valid = bus.req0_valid | bus.req1_valid;
    // Only the unit owning the current op can complete it.
    assign sel_done   = cur_q.is_div ? bus.div_done : bus.mult_done;
    assign done_rise  = sel_done & ~done_prev_q;
    assign start_code = cur_q.sgn ? 2'b10 : 2'b01;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_q       <= '0;
            pend_q      <= '0;
            pend_v_q    <= 1'b0;
            done_prev_q <= 1'b1;
            res_q       <= 64'd0;
            wdog_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            pend_q      <= pend_d;
            pend_v_q    <= pend_v_d;
            done_prev_q <= done_prev_d;
            res_q       <= res_d;
            wdog_q      <= wdog_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        pend_d      = pend_q;
        pend_v_d    = pend_v_q;
        res_d       = res_q;
        done_prev_d = sel_done;

        case (state_q)
            S_IDLE: begin
                if (!bus.flush && any_valid) begin
                    cur_d = bus.req0_valid ? slot0 : slot1;
                    if (bus.req0_valid && bus.req1_valid) begin
                        pend_d   = slot1;
                        pend_v_d = 1'b1;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (bus.flush) begin
                    pend_v_d = 1'b0;
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A unit that finishes as the flush arrives needs no draining.
                if (bus.flush) begin
                    pend_v_d = 1'b0;
                    state_d  = done_rise ? S_IDLE : S_DRAIN;
                end else if (done_rise) begin
                    res_d   = cur_q.is_div ? bus.div_result : bus.mult_result;
                    state_d = S_COMMIT;
                end
            end
            S_COMMIT: begin
                if (bus.flush) begin
                    pend_v_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (pend_v_q) begin
                    cur_d    = pend_q;
                    pend_v_d = 1'b0;
                    state_d  = S_ISSUE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (sel_done && done_prev_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wdog_d = 8'd0;
        if ((state_d == S_WAIT || state_d == S_DRAIN) && state_d == state_q) begin
            wdog_d = (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
        end
    end

    always_comb begin
        bus.mult_op    = 2'b00;
        bus.div_op     = 2'b00;
        bus.opa        = cur_q.a;
        bus.opb        = cur_q.b;
        bus.hilo_we    = 1'b0;
        bus.hilo_wdata = res_q;
        bus.busy       = (state_q != S_IDLE);
        bus.stall      = 1'b0;

        if (state_q == S_ISSUE && !bus.flush) begin
            if (cur_q.is_div) bus.div_op  = start_code;
            else              bus.mult_op = start_code;
        end
        if (state_q == S_COMMIT && !bus.flush) begin
            bus.hilo_we = 1'b1;
        end

        if (!bus.flush) begin
            case (state_q)
                S_IDLE:   bus.stall = any_valid;
                S_ISSUE:  bus.stall = 1'b1;
                S_WAIT:   bus.stall = 1'b1;
                S_COMMIT: bus.stall = pend_v_q;
                S_DRAIN:  bus.stall = any_valid;
                default:  bus.stall = 1'b0;
            endcase
        end
    end

    a_one_start: assert property (@(posedge clk) disable iff (reset)
        !((|bus.mult_op) && (|bus.div_op)));
    a_start_in_issue: assert property (@(posedge clk) disable iff (reset)
        ((|bus.mult_op) || (|bus.div_op)) |-> (state_q == S_ISSUE));
    a_wdog_scope: assert property (@(posedge clk) disable iff (reset)
        (wdog_q != 8'd0) |-> (state_q == S_WAIT || state_q == S_DRAIN));

endmodule
